// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronize, debounce and edge-detect switches, buttons and a scanned keypad
//
// Conditions raw asynchronous inputs into clean debounced levels with
// one-cycle rise/fall pulses, scans an active-low keypad matrix and
// generates button auto-repeat pulses.
//
// Ports:
//   clk                      system clock, all logic on the rising edge
//   rst                      asynchronous active-low reset
//   sw / bt / row            raw switch, button and keypad-row inputs
//   col                      keypad column drive, one-hot active-low
//   sw_level/rise/fall       debounced switch level and edge pulses
//   bt_level/rise/fall       debounced button level and edge pulses
//   bt_repeat                button auto-repeat pulse
//   key_level/rise/fall      debounced per-key state, index = col*KP_ROWS + row
//   key_any / key_code       any key down / lowest pressed key index
module input_conditioner #(
    parameter int N_SW        = 24,
    parameter int N_BT        = 5,
    parameter int KP_ROWS     = 4,
    parameter int KP_COLS     = 4,
    parameter int DB_CYCLES   = 20000,
    parameter int SCAN_CYCLES = 5000,
    parameter int RPT_DELAY   = 50000000,
    parameter int RPT_PERIOD  = 10000000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_SW-1:0]                      sw,
    input  logic [N_BT-1:0]                      bt,
    input  logic [KP_ROWS-1:0]                   row,
    output logic [KP_COLS-1:0]                   col,
    output logic [N_SW-1:0]                      sw_level,
    output logic [N_SW-1:0]                      sw_rise,
    output logic [N_SW-1:0]                      sw_fall,
    output logic [N_BT-1:0]                      bt_level,
    output logic [N_BT-1:0]                      bt_rise,
    output logic [N_BT-1:0]                      bt_fall,
    output logic [N_BT-1:0]                      bt_repeat,
    output logic [KP_ROWS*KP_COLS-1:0]           key_level,
    output logic [KP_ROWS*KP_COLS-1:0]           key_rise,
    output logic [KP_ROWS*KP_COLS-1:0]           key_fall,
    output logic                                 key_any,
    output logic [$clog2(KP_ROWS*KP_COLS)-1:0]   key_code
);

    localparam int NK       = KP_ROWS * KP_COLS;
    localparam int NCH      = N_SW + N_BT + NK;
    localparam int BT_BASE  = N_SW;
    localparam int KEY_BASE = N_SW + N_BT;
    localparam int DBW      = $clog2(DB_CYCLES + 1);
    localparam int SCW      = $clog2(SCAN_CYCLES);
    localparam int CIW      = $clog2(KP_COLS);
    localparam int HW       = $clog2(RPT_DELAY + 1);
    localparam int PW       = $clog2(RPT_PERIOD + 1);
    localparam int KCW      = $clog2(NK);

    // Input synchronizers
    logic [N_SW-1:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [N_BT-1:0]    bt_s1_q, bt_s1_d, bt_s2_q, bt_s2_d;
    logic [KP_ROWS-1:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;

    // Keypad scanner
    logic [SCW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [CIW-1:0]     col_idx_q, col_idx_d;
    logic [NK-1:0]      kraw_q, kraw_d;

    // Shared debounce/edge state for every channel: switches, buttons, keys
    logic [NCH-1:0]     din;
    logic [NCH-1:0]     lvl_q, lvl_d;
    logic [NCH-1:0]     rise_q, rise_d;
    logic [NCH-1:0]     fall_q, fall_d;
    logic [DBW-1:0]     db_cnt_q [NCH];
    logic [DBW-1:0]     db_cnt_d [NCH];

    // Button auto-repeat
    logic [HW-1:0]      hold_q [N_BT];
    logic [HW-1:0]      hold_d [N_BT];
    logic [PW-1:0]      per_q  [N_BT];
    logic [PW-1:0]      per_d  [N_BT];
    logic [N_BT-1:0]    rpt_q, rpt_d;

    assign din = {kraw_q, bt_s2_q, sw_s2_q};

    always_comb begin
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
        bt_s1_d  = bt;
        bt_s2_d  = bt_s1_q;
        row_s1_d = row;
        row_s2_d = row_s1_q;
    end

    // The row synchronizer lags the column drive by two clocks, so the rows
    // are only latched on the final dwell cycle of each column.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        col_idx_d  = col_idx_q;
        kraw_d     = kraw_q;
        if (scan_cnt_q == SCW'(SCAN_CYCLES - 1)) begin
            scan_cnt_d = '0;
            col_idx_d  = (col_idx_q == CIW'(KP_COLS - 1)) ? '0 : col_idx_q + 1'b1;
            for (int c = 0; c < KP_COLS; c++) begin
                if (col_idx_q == CIW'(c)) begin
                    for (int r = 0; r < KP_ROWS; r++) begin
                        kraw_d[c*KP_ROWS + r] = ~row_s2_q[r];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            lvl_d[i]    = lvl_q[i];
            rise_d[i]   = 1'b0;
            fall_d[i]   = 1'b0;
            db_cnt_d[i] = '0;
            if (din[i] != lvl_q[i]) begin
                // Flip on the edge where the disagreement count would hit DB_CYCLES
                if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    lvl_d[i]  = din[i];
                    rise_d[i] = din[i];
                    fall_d[i] = ~din[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end

        // Hold count is zero in the rise cycle and advances only while the
        // level stays high; once it saturates at RPT_DELAY the period counter
        // takes over. Any level change clears everything in the same edge.
        for (int b = 0; b < N_BT; b++) begin
            hold_d[b] = '0;
            per_d[b]  = '0;
            rpt_d[b]  = 1'b0;
            if (lvl_q[BT_BASE + b] && lvl_d[BT_BASE + b]) begin
                if (hold_q[b] != HW'(RPT_DELAY)) begin
                    hold_d[b] = hold_q[b] + 1'b1;
                    if (hold_q[b] == HW'(RPT_DELAY - 1)) begin
                        rpt_d[b] = 1'b1;
                    end
                end else begin
                    hold_d[b] = hold_q[b];
                    if (per_q[b] == PW'(RPT_PERIOD - 1)) begin
                        rpt_d[b] = 1'b1;
                    end else begin
                        per_d[b] = per_q[b] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            bt_s1_q    <= '0;
            bt_s2_q    <= '0;
            row_s1_q   <= '1;
            row_s2_q   <= '1;
            scan_cnt_q <= '0;
            col_idx_q  <= '0;
            kraw_q     <= '0;
            lvl_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            rpt_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int b = 0; b < N_BT; b++) begin
                hold_q[b] <= '0;
                per_q[b]  <= '0;
            end
        end else begin
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            bt_s1_q    <= bt_s1_d;
            bt_s2_q    <= bt_s2_d;
            row_s1_q   <= row_s1_d;
            row_s2_q   <= row_s2_d;
            scan_cnt_q <= scan_cnt_d;
            col_idx_q  <= col_idx_d;
            kraw_q     <= kraw_d;
            lvl_q      <= lvl_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rpt_q      <= rpt_d;
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int b = 0; b < N_BT; b++) begin
                hold_q[b] <= hold_d[b];
                per_q[b]  <= per_d[b];
            end
        end
    end

    assign sw_level  = lvl_q[N_SW-1:0];
    assign sw_rise   = rise_q[N_SW-1:0];
    assign sw_fall   = fall_q[N_SW-1:0];
    assign bt_level  = lvl_q[BT_BASE +: N_BT];
    assign bt_rise   = rise_q[BT_BASE +: N_BT];
    assign bt_fall   = fall_q[BT_BASE +: N_BT];
    assign bt_repeat = rpt_q;
    assign key_level = lvl_q[KEY_BASE +: NK];
    assign key_rise  = rise_q[KEY_BASE +: NK];
    assign key_fall  = fall_q[KEY_BASE +: NK];
    assign key_any   = |key_level;

    always_comb begin
        col = '1;
        for (int c = 0; c < KP_COLS; c++) begin
            col[c] = (col_idx_q != CIW'(c));
        end
        // Walk downward so the lowest set index wins
        key_code = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (key_level[i]) begin
                key_code = KCW'(i);
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized self-checking bench for input_conditioner
module tb_input_conditioner;

    localparam int N_SW    = 24;
    localparam int N_BT    = 5;
    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int NK      = KP_ROWS * KP_COLS;
    localparam int NSB     = N_SW + N_BT;
    localparam int DB      = 4;
    localparam int SCAN    = 4;
    localparam int RD      = 10;
    localparam int RP      = 3;

    logic                 clk;
    logic                 rst;
    logic [N_SW-1:0]      sw;
    logic [N_BT-1:0]      bt;
    logic [KP_ROWS-1:0]   row;
    logic [KP_COLS-1:0]   col;
    logic [N_SW-1:0]      sw_level, sw_rise, sw_fall;
    logic [N_BT-1:0]      bt_level, bt_rise, bt_fall, bt_repeat;
    logic [NK-1:0]        key_level, key_rise, key_fall;
    logic                 key_any;
    logic [$clog2(NK)-1:0] key_code;

    logic [NK-1:0]        pressed;

    input_conditioner #(
        .N_SW(N_SW), .N_BT(N_BT), .KP_ROWS(KP_ROWS), .KP_COLS(KP_COLS),
        .DB_CYCLES(DB), .SCAN_CYCLES(SCAN), .RPT_DELAY(RD), .RPT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .bt(bt), .row(row), .col(col),
        .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .bt_level(bt_level), .bt_rise(bt_rise), .bt_fall(bt_fall), .bt_repeat(bt_repeat),
        .key_level(key_level), .key_rise(key_rise), .key_fall(key_fall),
        .key_any(key_any), .key_code(key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row low while its column is driven low
    always_comb begin
        row = '1;
        for (int c = 0; c < KP_COLS; c++)
            for (int r = 0; r < KP_ROWS; r++)
                if (!col[c] && pressed[c*KP_ROWS + r]) row[r] = 1'b0;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: a channel's level flips when the DB raw samples taken
    // from DB+1 to 2 edges ago all disagree with it (two sync stages of lag).
    logic [NSB-1:0]  hist[$];
    logic [NSB-1:0]  m_lvl, m_rise, m_fall;
    logic [N_BT-1:0] m_rpt;
    int              m_k[N_BT];
    int              edges;
    bit              in_rst;
    logic [NK-1:0]   k_rise_acc, k_rise_multi, k_fall_acc, k_fall_multi;

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j <= DB; j++) hist.push_back('0);
        m_lvl = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
        for (int b = 0; b < N_BT; b++) m_k[b] = 0;
        edges = 0;
    endtask

    task automatic model_step();
        logic [NSB-1:0] flip;
        logic [NSB-1:0] old;
        old  = m_lvl;
        flip = '1;
        for (int j = 1; j <= DB; j++) flip &= (hist[j] ^ old);
        m_lvl  = old ^ flip;
        m_rise = flip & m_lvl;
        m_fall = flip & ~m_lvl;
        hist.push_front({bt, sw});
        void'(hist.pop_back());
        for (int b = 0; b < N_BT; b++) begin
            if (m_rise[N_SW+b])     m_k[b] = 0;
            else if (m_lvl[N_SW+b]) m_k[b] = m_k[b] + 1;
            else                    m_k[b] = 0;
            m_rpt[b] = m_lvl[N_SW+b] && !m_rise[N_SW+b] && (m_k[b] >= RD) && (((m_k[b] - RD) % RP) == 0);
        end
    endtask

    function automatic logic [KP_COLS-1:0] exp_col(input int e);
        logic [KP_COLS-1:0] v;
        v = '1;
        v[(e / SCAN) % KP_COLS] = 1'b0;
        return v;
    endfunction

    function automatic int lowest(input logic [NK-1:0] v);
        int r;
        r = 0;
        for (int i = NK - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, ":sw_level"},  sw_level,  0);
        check_eq({tag, ":sw_rise"},   sw_rise,   0);
        check_eq({tag, ":sw_fall"},   sw_fall,   0);
        check_eq({tag, ":bt_level"},  bt_level,  0);
        check_eq({tag, ":bt_rise"},   bt_rise,   0);
        check_eq({tag, ":bt_fall"},   bt_fall,   0);
        check_eq({tag, ":bt_repeat"}, bt_repeat, 0);
        check_eq({tag, ":key_level"}, key_level, 0);
        check_eq({tag, ":key_rise"},  key_rise,  0);
        check_eq({tag, ":key_fall"},  key_fall,  0);
        check_eq({tag, ":key_any"},   key_any,   0);
        check_eq({tag, ":key_code"},  key_code,  0);
        check_eq({tag, ":col"},       col,       exp_col(0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!in_rst) begin
            model_step();
            edges++;
        end
        #1;
        if (in_rst) begin
            check_zero("in_rst");
        end else begin
            check_eq("sw_level",  sw_level,  m_lvl[N_SW-1:0]);
            check_eq("sw_rise",   sw_rise,   m_rise[N_SW-1:0]);
            check_eq("sw_fall",   sw_fall,   m_fall[N_SW-1:0]);
            check_eq("bt_level",  bt_level,  m_lvl[NSB-1:N_SW]);
            check_eq("bt_rise",   bt_rise,   m_rise[NSB-1:N_SW]);
            check_eq("bt_fall",   bt_fall,   m_fall[NSB-1:N_SW]);
            check_eq("bt_repeat", bt_repeat, m_rpt);
            check_eq("col",       col,       exp_col(edges));
            check_eq("key_rise_and_fall", key_rise & key_fall, 0);
            k_rise_multi |= k_rise_acc & key_rise;
            k_rise_acc   |= key_rise;
            k_fall_multi |= k_fall_acc & key_fall;
            k_fall_acc   |= key_fall;
        end
    endtask

    task automatic do_reset(input bit check_now, input int cycles);
        rst = 1'b0;
        in_rst = 1'b1;
        model_reset();
        #1;
        if (check_now) check_zero("rst_immediate");
        repeat (cycles) tick();
        rst = 1'b1;
        in_rst = 1'b0;
    endtask

    task automatic key_phase(input logic [NK-1:0] nxt, input string tag);
        logic [NK-1:0] old;
        old = pressed;
        pressed = nxt;
        k_rise_acc = '0; k_rise_multi = '0; k_fall_acc = '0; k_fall_multi = '0;
        repeat (48) tick();
        check_eq({tag, ":key_level"}, key_level, nxt);
        check_eq({tag, ":key_rise_set"}, k_rise_acc, nxt & ~old);
        check_eq({tag, ":key_fall_set"}, k_fall_acc, old & ~nxt);
        check_eq({tag, ":key_pulse_once"}, k_rise_multi | k_fall_multi, 0);
        check_eq({tag, ":key_any"}, key_any, |nxt);
        check_eq({tag, ":key_code"}, key_code, lowest(nxt));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rises, first_off, nrep, exp_rep;
        logic act;
        logic [31:0] r1, r2, rk;

        sw = '0; bt = '0; pressed = '0;
        k_rise_acc = '0; k_rise_multi = '0; k_fall_acc = '0; k_fall_multi = '0;
        do_reset(1'b0, 4);
        repeat (3) tick();

        // Single switch rise: level appears DB+1 edges after the sampling edge
        sw = 24'h000008;
        n = 0; rises = 0;
        while (!sw_level[3] && n < 20) begin
            tick(); n++;
            if (sw_rise[3]) rises++;
        end
        check_eq("sw3_latency_edges", n - 1, DB + 1);
        repeat (5) begin tick(); if (sw_rise[3]) rises++; end
        check_eq("sw3_rise_count", rises, 1);

        // Short button glitch is swallowed
        act = 1'b0;
        bt = 5'b00001;
        repeat (3) begin tick(); act |= bt_level[0] | bt_rise[0] | bt_fall[0]; end
        bt = 5'b00000;
        repeat (12) begin tick(); act |= bt_level[0] | bt_rise[0] | bt_fall[0]; end
        check_eq("bt0_glitch_activity", act, 0);

        // Held button auto-repeat
        bt = 5'b00010;
        n = 0;
        while (!bt_rise[1] && n < 20) begin tick(); n++; end
        check_eq("bt1_rise_seen", bt_rise[1], 1);
        nrep = 0; first_off = -1; exp_rep = 0;
        for (int off = 1; off <= 30; off++) begin
            tick();
            if (bt_repeat[1]) begin
                nrep++;
                if (first_off < 0) first_off = off;
            end
            if (off >= RD && ((off - RD) % RP) == 0) exp_rep++;
        end
        check_eq("bt1_first_repeat_offset", first_off, RD);
        check_eq("bt1_repeat_count", nrep, exp_rep);
        bt = 5'b00000;
        n = 0;
        while (!bt_fall[1] && n < 20) begin tick(); n++; end
        check_eq("bt1_fall_seen", bt_fall[1], 1);
        check_eq("bt1_repeat_in_fall_cycle", bt_repeat[1], 0);
        act = 1'b0;
        repeat (8) begin tick(); act |= bt_repeat[1]; end
        check_eq("bt1_repeat_after_release", act, 0);

        // Keypad: col 2/row 1 is key 9, col 0/row 3 is key 3
        key_phase(16'h0200, "key9");
        key_phase(16'h0208, "key9_key3");
        key_phase(16'h0000, "key_clear");

        // Reset in the middle of a button hold discards all progress
        bt = 5'b00010;
        n = 0;
        while (!bt_rise[1] && n < 20) begin tick(); n++; end
        check_eq("bt1_rise_before_rst", bt_rise[1], 1);
        repeat (8) tick();
        do_reset(1'b1, 3);
        n = 0;
        while (!bt_repeat[1] && n < 40) begin tick(); n++; end
        check_eq("bt1_first_repeat_after_rst", n, DB + 1 + RD + 1);
        bt = 5'b00000;
        repeat (10) tick();

        // Randomized switch and button activity with mixed glitch and hold lengths
        for (int s = 0; s < 800; s++) begin
            r1 = $urandom & $urandom & $urandom;
            r2 = $urandom & $urandom;
            sw = sw ^ r1[N_SW-1:0];
            bt = bt ^ r2[N_BT-1:0];
            repeat ($urandom_range(1, 10)) tick();
        end

        // Randomized keypad chords
        for (int s = 0; s < 8; s++) begin
            rk = $urandom & $urandom;
            key_phase(rk[NK-1:0], "key_rand");
        end
        key_phase(16'h0000, "key_rand_clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_SW, default 24, number of slide-switch channels (1..32).
REQ-002 Parameter N_BT, default 5, number of push-button channels (1..8).
REQ-003 Parameter KP_ROWS, default 4, and KP_COLS, default 4, keypad matrix size (2..8 each); NK = KP_ROWS*KP_COLS.
REQ-004 Parameter DB_CYCLES, default 20000, debounce stability length in clocks (>=1).
REQ-005 Parameter SCAN_CYCLES, default 5000, keypad column dwell in clocks (>=4).
REQ-006 Parameter RPT_DELAY, default 50000000, and RPT_PERIOD, default 10000000, button auto-repeat timing in clocks (both >=1).
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-009 sw  in  N_SW  raw switch levels, asynchronous.
REQ-010 bt  in  N_BT  raw button levels, active-high, asynchronous.
REQ-011 row  in  KP_ROWS  keypad rows, active-low, asynchronous.
REQ-012 col  out  KP_COLS  keypad column drive, one-hot active-low.
REQ-013 sw_level / sw_rise / sw_fall  out  N_SW each  debounced level, 1-cycle rise pulse, 1-cycle fall pulse.
REQ-014 bt_level / bt_rise / bt_fall / bt_repeat  out  N_BT each  as above plus auto-repeat pulse.
REQ-015 key_level / key_rise / key_fall  out  NK each  debounced per-key state; key index = col_idx*KP_ROWS + row_idx.
REQ-016 key_any  out  1  OR of key_level; key_code  out  clog2(NK)  index of lowest-numbered pressed key.

Function
REQ-017 Every raw input (sw, bt, row) SHALL pass a 2-flop synchronizer before any other logic.
REQ-018 Each channel SHALL own a debounce counter that increments while synchronized value != level and clears whenever they match.
REQ-019 When the counter would reach DB_CYCLES, level SHALL take the synchronized value and the counter SHALL clear in the same edge.
REQ-020 A raw change held stable SHALL appear on level exactly DB_CYCLES+1 edges after the edge that first samples it; any glitch shorter than DB_CYCLES cycles SHALL produce no level change.
REQ-021 rise/fall SHALL be registered pulses asserted for exactly the one cycle in which level is first observed new; rise and fall never coexist on a channel.
REQ-022 Keypad scanner SHALL drive col low on col_idx only, dwelling SCAN_CYCLES clocks per column, col_idx wrapping KP_COLS-1 -> 0.
REQ-023 On the last dwell cycle the scanner SHALL latch inverted synchronized row into the raw key bits of the current column, then advance col_idx; other columns' raw bits hold.
REQ-024 Raw key bits SHALL feed the same debounce/edge logic as REQ-018..021; multiple simultaneous keys SHALL all be reported.
REQ-025 key_code SHALL be the lowest set index of key_level, 0 when key_any = 0; both combinational from key_level.
REQ-026 Per button, a hold counter SHALL clear on bt_rise and count while bt_level = 1, saturating at its top.
REQ-027 bt_repeat SHALL pulse one cycle when hold count reaches RPT_DELAY, then every RPT_PERIOD cycles while held; never in the bt_rise cycle, never when bt_level = 0.
REQ-028 Release (bt_fall) SHALL clear the hold counter and stop repeats in that same cycle.

Reset
REQ-029 During rst = 0: all level/rise/fall/repeat outputs 0, key_any 0, key_code 0, all counters 0, col_idx 0, col = all ones except bit 0 low.
REQ-030 Switch/button synchronizers SHALL reset to 0, row synchronizers to all ones; raw key bits to 0.
REQ-031 After reset release, an input already high SHALL produce a normal rise after DB_CYCLES+1 edges (no suppression).
REQ-032 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse emitted on release.

Verification (DB_CYCLES=4, SCAN_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3 unless noted)
REQ-033 sw[3] 0->1 held -> sw_level[3] high 5 edges after sampling edge, sw_rise[3] single 1-cycle pulse, other bits quiet.
REQ-034 bt[0] high for 3 cycles then low -> no bt_level, bt_rise or bt_fall activity.
REQ-035 bt[1] held 30 cycles past rise -> bt_repeat[1] at hold counts 10, 13, 16, ...; release -> bt_fall[1], repeats stop same cycle.
REQ-036 Keypad col 2 / row 1 held low -> key_level[9]=1, key_rise[9] once, key_any=1, key_code=9; add col 0 / row 3 -> key_code=3.
REQ-037 col observed over 20 cycles after reset -> 1110,1101,1011,0111 each 4 cycles, then wrap to 1110.
REQ-038 rst pulsed low during bt hold at count 8 -> all outputs 0 immediately; after release no bt_repeat before a fresh rise + 10 cycles.
